pc_sequencer: RTL



---
 rtl/pc_sequencer.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle fetch/execute sequencer that owns the program
// counter, issues instruction fetches and resolves the next PC once the
// datapath reports completion (branch target when zero & branch, else PC+4).
module pc_sequencer #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned EXEC_TIMEOUT = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        halt,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        exec_done,
    input  logic        zero,
    input  logic        branch,
    input  logic [31:0] branch_target,
    output logic [31:0] pc,
    output logic        pc_write,
    output logic [31:0] retired,
    output logic        busy,
    output logic        error
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_EXEC   = 3'd2,
        S_UPDATE = 3'd3,
        S_HALTED = 3'd4,
        S_ERROR  = 3'd5
    } state_t;

    // Last counter value that is still allowed in EXEC; reaching it without
    // exec_done means the datapath has hung.
    localparam logic [7:0] TIMEOUT_LAST = 8'(EXEC_TIMEOUT - 32'd1);

    state_t      state_r,   state_s;
    logic [31:0] pc_r,      pc_s;
    logic [31:0] instr_r,   instr_s;
    logic [31:0] retired_r, retired_s;
    logic [31:0] next_pc_r, next_pc_s;
    logic [7:0]  tcnt_r,    tcnt_s;
    logic        taken_s;

    // Word alignment test for a candidate PC.
    function automatic logic is_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

    // Next-state and datapath-register update logic for the sequencer.
    always_comb begin
        state_s   = state_r;
        pc_s      = pc_r;
        instr_s   = instr_r;
        retired_s = retired_r;
        next_pc_s = next_pc_r;
        tcnt_s    = tcnt_r;
        taken_s   = zero & branch;

        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_s = S_FETCH;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_FETCH: begin
                if (imem_ack) begin
                    instr_s = imem_rdata;
                    tcnt_s  = 8'd0;
                    state_s = S_EXEC;
                end else begin
                    state_s = S_FETCH;
                end
            end
            S_EXEC: begin
                // A completion on the final allowed cycle still counts as done.
                if (exec_done) begin
                    if (taken_s) begin
                        next_pc_s = branch_target;
                    end else begin
                        next_pc_s = pc_r + 32'd4;
                    end
                    state_s = S_UPDATE;
                end else if (tcnt_r == TIMEOUT_LAST) begin
                    state_s = S_ERROR;
                end else begin
                    tcnt_s  = tcnt_r + 8'd1;
                    state_s = S_EXEC;
                end
            end
            S_UPDATE: begin
                // A misaligned target leaves pc and retired untouched.
                if (!is_aligned(next_pc_r)) begin
                    state_s = S_ERROR;
                end else begin
                    pc_s      = next_pc_r;
                    retired_s = retired_r + 32'd1;
                    if (halt) begin
                        state_s = S_HALTED;
                    end else begin
                        state_s = S_FETCH;
                    end
                end
            end
            S_HALTED: begin
                if (start) begin
                    state_s = S_FETCH;
                end else begin
                    state_s = S_HALTED;
                end
            end
            S_ERROR: begin
                state_s = S_ERROR;
            end
            default: begin
                // Unreachable encodings are treated as a fault.
                state_s = S_ERROR;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r   <= S_IDLE;
            pc_r      <= RESET_PC;
            instr_r   <= 32'h0000_0000;
            retired_r <= 32'h0000_0000;
            next_pc_r <= RESET_PC;
            tcnt_r    <= 8'd0;
        end else begin
            state_r   <= state_s;
            pc_r      <= pc_s;
            instr_r   <= instr_s;
            retired_r <= retired_s;
            next_pc_r <= next_pc_s;
            tcnt_r    <= tcnt_s;
        end
    end

    // All outputs are decoded from registers only; no input reaches an output
    // combinationally.
    assign imem_req    = (state_r == S_FETCH);
    assign imem_addr   = pc_r;
    assign instr       = instr_r;
    assign instr_valid = (state_r == S_EXEC);
    assign pc          = pc_r;
    assign pc_write    = (state_r == S_UPDATE) && is_aligned(next_pc_r);
    assign retired     = retired_r;
    assign busy        = (state_r == S_FETCH) || (state_r == S_EXEC) ||
                         (state_r == S_UPDATE);
    assign error       = (state_r == S_ERROR);

endmodule
